// File: rtl/ntt_ctrl.sv
// Address/control sequencer for an in-place forward NTT: walks the butterfly schedule
// layer by layer and ping-pongs between two RAM banks through a LAT-deep write pipeline.
module ntt_ctrl #(
    parameter int DEPTH = 8,
    parameter int LAT   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [DEPTH-1:0] rd_addr_lo,
    output logic [DEPTH-1:0] rd_addr_hi,
    output logic [6:0]       zeta_k,
    output logic             rd_bank,
    output logic             wr_en,
    output logic [DEPTH-1:0] wr_addr_lo,
    output logic [DEPTH-1:0] wr_addr_hi,
    output logic             wr_bank,
    output logic             result_bank
);

    localparam int LW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [LW-1:0] LAST_LAYER  = LW'(DEPTH - 2);
    localparam logic [LW-1:0] TOP_SHIFT   = LW'(DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(LAT - 1);
    localparam logic          RESULT_BANK = ((DEPTH - 2) % 2) == 0;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [LW-1:0]    layer;
    logic [DEPTH-1:0] j;
    logic [DEPTH-1:0] len;
    logic [DEPTH-1:0] j_inc;
    logic [DEPTH-2:0] issue_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [6:0]       zeta;
    logic             issue;
    logic             layer_last_issue;
    logic             group_end;
    logic             last_layer;
    logic             drain_end;

    logic             pipe_en   [LAT];
    logic [DEPTH-1:0] pipe_lo   [LAT];
    logic [DEPTH-1:0] pipe_hi   [LAT];
    logic             pipe_bank [LAT];

    // len halves every layer, starting at N/2
    assign len              = {{(DEPTH-1){1'b0}}, 1'b1} << (TOP_SHIFT - layer);
    assign j_inc            = j + 1'b1;
    assign group_end        = (j_inc & (len - 1'b1)) == '0;
    assign issue            = (state == READ) && !hold;
    assign layer_last_issue = issue && (issue_cnt == '1);
    assign last_layer       = layer == LAST_LAYER;
    assign drain_end        = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    assign busy        = (state == READ) || (state == DRAIN);
    assign done        = state == DONE;
    assign rd_en       = issue;
    assign rd_addr_lo  = issue ? j : '0;
    assign rd_addr_hi  = issue ? (j + len) : '0;
    assign zeta_k      = zeta;
    assign rd_bank     = layer[0];
    assign result_bank = RESULT_BANK;

    assign wr_en      = pipe_en[LAT-1];
    assign wr_addr_lo = pipe_lo[LAT-1];
    assign wr_addr_hi = pipe_hi[LAT-1];
    assign wr_bank    = pipe_bank[LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (layer_last_issue) state_next = DRAIN;
            DRAIN:   if (drain_end) state_next = last_layer ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final group of a layer also bumps zeta, except at the very end of the transform
    always_ff @(posedge clk) begin
        if (reset) begin
            layer     <= '0;
            j         <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            zeta      <= 7'd1;
        end else begin
            if ((state == IDLE) && start) begin
                layer     <= '0;
                j         <= '0;
                issue_cnt <= '0;
                drain_cnt <= '0;
                zeta      <= 7'd1;
            end
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (layer_last_issue) begin
                    j <= '0;
                    if (!last_layer) zeta <= zeta + 7'd1;
                end else if (group_end) begin
                    j    <= j_inc + len;
                    zeta <= zeta + 7'd1;
                end else begin
                    j <= j_inc;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                if (drain_end) begin
                    drain_cnt <= '0;
                    if (!last_layer) layer <= layer + 1'b1;
                end
            end
        end
    end

    // Write-back delay line; bubbles travel through as zeros so writes stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_en[i]   <= 1'b0;
                pipe_lo[i]   <= '0;
                pipe_hi[i]   <= '0;
                pipe_bank[i] <= 1'b0;
            end
        end else begin
            pipe_en[0]   <= rd_en;
            pipe_lo[0]   <= rd_addr_lo;
            pipe_hi[0]   <= rd_addr_hi;
            pipe_bank[0] <= rd_en & ~rd_bank;
            for (int i = 1; i < LAT; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_lo[i]   <= pipe_lo[i-1];
                pipe_hi[i]   <= pipe_hi[i-1];
                pipe_bank[i] <= pipe_bank[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: a schedule-list reference model checked every cycle on a DEPTH=4
// instance, plus directed timing/count checks on DEPTH=4 and DEPTH=8 instances.
module tb_ntt_ctrl;

    localparam int DEPTH = 4;
    localparam int LAT   = 5;
    localparam int N     = 1 << DEPTH;
    localparam int HALF  = N / 2;
    localparam int TOTAL = HALF * (DEPTH - 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic start_8 = 1'b0;

    logic             busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
    logic [DEPTH-1:0] rd_addr_lo, rd_addr_hi, wr_addr_lo, wr_addr_hi;
    logic [6:0]       zeta_k;

    logic       busy_8, done_8, rd_en_8, rd_bank_8, wr_en_8, wr_bank_8, result_bank_8;
    logic [7:0] rd_addr_lo_8, rd_addr_hi_8, wr_addr_lo_8, wr_addr_hi_8;
    logic [6:0] zeta_k_8;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int t0 = 0;
    int t08 = 0;

    int ex_lo [TOTAL];
    int ex_hi [TOTAL];
    int ex_k  [TOTAL];

    bit m_active = 0;
    bit m_done = 0;
    int m_idx = 0;
    int m_drain = 0;
    bit m_rd;
    bit exp_rd;
    int p_en   [LAT];
    int p_lo   [LAT];
    int p_hi   [LAT];
    int p_bank [LAT];

    int done_cnt, done_cyc, rd_cnt, bank_bits, first_lo, first_hi, first_k;
    int rd8_cnt, last_k8, done8_cnt, done8_cyc;

    always #5 clk = ~clk;

    ntt_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi), .zeta_k(zeta_k),
        .rd_bank(rd_bank), .wr_en(wr_en), .wr_addr_lo(wr_addr_lo),
        .wr_addr_hi(wr_addr_hi), .wr_bank(wr_bank), .result_bank(result_bank)
    );

    ntt_ctrl #(.DEPTH(8), .LAT(LAT)) dut8 (
        .clk(clk), .reset(reset), .start(start_8), .hold(1'b0),
        .busy(busy_8), .done(done_8), .rd_en(rd_en_8),
        .rd_addr_lo(rd_addr_lo_8), .rd_addr_hi(rd_addr_hi_8), .zeta_k(zeta_k_8),
        .rd_bank(rd_bank_8), .wr_en(wr_en_8), .wr_addr_lo(wr_addr_lo_8),
        .wr_addr_hi(wr_addr_hi_8), .wr_bank(wr_bank_8), .result_bank(result_bank_8)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Flat butterfly schedule: layer by layer, group by group, one zeta per group
    task automatic build_schedule();
        int i = 0;
        int k = 0;
        for (int l = 0; l < DEPTH - 1; l++) begin
            int len = N >> (l + 1);
            for (int st = 0; st < N; st += 2 * len) begin
                k++;
                for (int jj = st; jj < st + len; jj++) begin
                    ex_lo[i] = jj;
                    ex_hi[i] = jj + len;
                    ex_k[i]  = k;
                    i++;
                end
            end
        end
    endtask

    // Reference model: a pointer into the schedule, a drain countdown and a write queue
    always @(posedge clk) begin
        edge_cnt++;
        m_rd = m_active && !m_done && (m_drain == 0) && (m_idx < TOTAL) && !hold;
        for (int i = LAT - 1; i > 0; i--) begin
            p_en[i] = p_en[i-1];
            p_lo[i] = p_lo[i-1];
            p_hi[i] = p_hi[i-1];
            p_bank[i] = p_bank[i-1];
        end
        p_en[0]   = m_rd ? 1 : 0;
        p_lo[0]   = m_rd ? ex_lo[m_idx] : 0;
        p_hi[0]   = m_rd ? ex_hi[m_idx] : 0;
        p_bank[0] = m_rd ? 1 - ((m_idx / HALF) % 2) : 0;
        if (reset) begin
            m_active = 0;
            m_done = 0;
            m_idx = 0;
            m_drain = 0;
            for (int i = 0; i < LAT; i++) begin
                p_en[i] = 0;
                p_lo[i] = 0;
                p_hi[i] = 0;
                p_bank[i] = 0;
            end
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_idx = 0;
                m_drain = 0;
            end
        end else if (m_done) begin
            m_done = 0;
            m_active = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0 && m_idx == TOTAL) m_done = 1;
        end else if (m_rd) begin
            m_idx++;
            if (m_idx % HALF == 0) m_drain = LAT;
        end
    end

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            exp_rd = m_active && !m_done && (m_drain == 0) && (m_idx < TOTAL) && !hold;
            checkOutput("rd_en", int'(rd_en), int'(exp_rd));
            checkOutput("busy", int'(busy), int'(m_active && !m_done));
            checkOutput("done", int'(done), int'(m_done));
            if (exp_rd && rd_en) begin
                checkOutput("rd_addr_lo", int'(rd_addr_lo), ex_lo[m_idx]);
                checkOutput("rd_addr_hi", int'(rd_addr_hi), ex_hi[m_idx]);
                checkOutput("zeta_k", int'(zeta_k), ex_k[m_idx]);
                checkOutput("rd_bank", int'(rd_bank), (m_idx / HALF) % 2);
            end
            checkOutput("wr_en", int'(wr_en), p_en[LAT-1]);
            if (wr_en && p_en[LAT-1] != 0) begin
                checkOutput("wr_addr_lo", int'(wr_addr_lo), p_lo[LAT-1]);
                checkOutput("wr_addr_hi", int'(wr_addr_hi), p_hi[LAT-1]);
                checkOutput("wr_bank", int'(wr_bank), p_bank[LAT-1]);
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = edge_cnt - t0 + 1;
        end
        if (rd_en) begin
            if (rd_cnt == 0) begin
                first_lo = int'(rd_addr_lo);
                first_hi = int'(rd_addr_hi);
                first_k  = int'(zeta_k);
            end
            if (rd_cnt % HALF == 0) bank_bits = bank_bits * 2 + int'(rd_bank);
            rd_cnt++;
        end
        if (rd_en_8) begin
            rd8_cnt++;
            last_k8 = int'(zeta_k_8);
        end
        if (done_8) begin
            done8_cnt++;
            done8_cyc = edge_cnt - t08 + 1;
        end
    end

    task automatic check_reset_values();
        checkOutput("reset_outputs",
                    int'({busy, done, rd_en, wr_en, rd_bank, wr_bank,
                          rd_addr_lo, rd_addr_hi, wr_addr_lo, wr_addr_hi}), 0);
        checkOutput("reset_zeta_k", int'(zeta_k), 1);
    endtask

    // Start is sampled at edge 0; iteration c drives the inputs seen during cycle c
    task automatic applyStimulus(input int max_cycles, input int hold_lo, input int hold_hi,
                                 input int start_a, input int start_b, input int reset_at,
                                 input int idle_at, input bit rand_mode);
        done_cnt = 0;
        rd_cnt = 0;
        bank_bits = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        start = 1'b0;
        for (int c = 1; c <= max_cycles; c++) begin
            if (c == idle_at) checkOutput("idle_after_done", int'({busy, done, rd_en}), 0);
            if (rand_mode) begin
                hold  = ($urandom_range(3) == 0);
                start = (done_cnt == 0) && (reset_at < 0 || c < reset_at) &&
                        ($urandom_range(7) == 0);
            end else begin
                hold  = (c >= hold_lo) && (c <= hold_hi);
                start = (c == start_a) || (c == start_b);
            end
            reset = (c == reset_at);
            @(posedge clk);
            #1;
            if (c == reset_at) check_reset_values();
        end
        hold = 1'b0;
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        build_schedule();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values();
        checkOutput("result_bank", int'(result_bank), 1);
        checkOutput("result_bank_8", int'(result_bank_8), 1);

        applyStimulus(45, 0, -1, -1, -1, -1, -1, 1'b0);
        checkOutput("plain_done_cycle", done_cyc, 40);
        checkOutput("plain_done_count", done_cnt, 1);
        checkOutput("plain_rd_count", rd_cnt, 24);
        checkOutput("first_rd_lo", first_lo, 0);
        checkOutput("first_rd_hi", first_hi, 8);
        checkOutput("first_zeta_k", first_k, 1);
        checkOutput("rd_bank_sequence_010", bank_bits, 2);

        applyStimulus(50, 3, 5, -1, -1, -1, -1, 1'b0);
        checkOutput("hold_done_cycle", done_cyc, 43);
        checkOutput("hold_done_count", done_cnt, 1);
        checkOutput("hold_rd_count", rd_cnt, 24);

        applyStimulus(45, 0, -1, 10, 40, -1, 41, 1'b0);
        checkOutput("stray_start_done_cycle", done_cyc, 40);
        checkOutput("stray_start_done_count", done_cnt, 1);

        applyStimulus(30, 0, -1, -1, -1, 20, -1, 1'b0);
        checkOutput("reset_mid_done_count", done_cnt, 0);
        checkOutput("reset_mid_rd_count", rd_cnt, 15);

        applyStimulus(45, 0, -1, -1, -1, -1, -1, 1'b0);
        checkOutput("rerun_done_cycle", done_cyc, 40);
        checkOutput("rerun_done_count", done_cnt, 1);

        for (int r = 0; r < 5; r++) begin
            applyStimulus(200, 0, -1, -1, -1, -1, -1, 1'b1);
            checkOutput("random_done_count", done_cnt, 1);
            checkOutput("random_rd_count", rd_cnt, 24);
        end
        applyStimulus(60, 0, -1, -1, -1, int'($urandom_range(35, 2)), -1, 1'b1);
        checkOutput("random_reset_done_count", done_cnt, 0);

        rd8_cnt = 0;
        done8_cnt = 0;
        start_8 = 1'b1;
        @(posedge clk);
        #1;
        t08 = edge_cnt;
        start_8 = 1'b0;
        for (int c = 1; c <= 1000 && done8_cnt == 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("depth8_rd_count", rd8_cnt, 896);
        checkOutput("depth8_final_zeta_k", last_k8, 127);
        checkOutput("depth8_done_cycle", done8_cyc, 932);
        checkOutput("depth8_done_count", done8_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
